zap_wb_arbiter: RTL and testbench
=================================

Name: zap_wb_arbiter

Overview:
- Two-master Wishbone B3 arbiter. Shares the single external bus between the code cache refill/write port and the data cache refill/write port.
- Sits between the two cache bus outputs and the bus-width adapter.
- Fixed data-over-code priority, with a starvation counter that forces a code grant after STARVE_LIMIT consecutive data wins.
- Grant is held for the whole CYC assertion, so incrementing bursts (CTI 010 ... 111) are never split.

Parameters:
- STARVE_LIMIT, 4: consecutive contested data grants before code is forced. 0 = code wins every tie.
- CNT_W, 4: starvation counter width. STARVE_LIMIT must be < 2**CNT_W.

Ports:
- i_clk  in  1  core clock
- i_reset  in  1  reset, asynchronous, active-high
- i_c_wb_cyc / i_c_wb_stb / i_c_wb_wen  in  1 each  code master cycle, strobe, write enable
- i_c_wb_sel  in  4  code byte selects
- i_c_wb_dat  in  32  code write data
- i_c_wb_adr  in  32  code address
- i_c_wb_cti  in  3  code cycle type
- o_c_wb_ack  out  1  ack routed to code master
- i_d_wb_cyc / i_d_wb_stb / i_d_wb_wen / i_d_wb_sel / i_d_wb_dat / i_d_wb_adr / i_d_wb_cti  in  1/1/1/4/32/32/3  data master, same meaning as code master
- o_d_wb_ack  out  1  ack routed to data master
- o_wb_cyc / o_wb_stb / o_wb_wen  out  1 each  merged bus
- o_wb_sel  out  4  merged bus byte selects
- o_wb_dat  out  32  merged bus write data
- o_wb_adr  out  32  merged bus address
- o_wb_cti  out  3  merged bus cycle type
- i_wb_ack  in  1  slave ack. Read data is broadcast to both caches outside this block.
- o_grant  out  2  01 = code, 10 = data, 00 = idle

Behaviour:
- FSM states: IDLE, GNT_C, GNT_D. State register, starvation counter and o_grant are flops. Bus outputs are a combinational mux selected by state.
- Reset (async, any state, including mid-burst):
  - state = IDLE, counter = 0.
  - All outputs 0: cyc, stb, wen, sel, dat, adr, cti, both acks, o_grant.
  - Masters are expected to abandon their cycle; the arbiter holds no memory of it.
- IDLE:
  - Bus outputs all 0; both acks 0.
  - Next state:
    - only i_c_wb_cyc high -> GNT_C
    - only i_d_wb_cyc high -> GNT_D
    - both high -> GNT_C if counter >= STARVE_LIMIT, else GNT_D
    - neither high -> stay in IDLE
  - Arbitration latency: 1 cycle. A request seen in IDLE appears on o_wb_* in the following cycle.
- Starvation counter:
  - On IDLE->GNT_D with i_c_wb_cyc high: increment, saturating at 2**CNT_W-1.
  - On IDLE->GNT_C: clear to 0.
  - Uncontested GNT_D: hold.
- GNT_x:
  - o_wb_* = i_x_wb_* (all seven signals).
  - o_x_wb_ack = i_wb_ack. The other master's ack = 0.
  - o_grant reflects x.
  - Stay while i_x_wb_cyc = 1. The other master's requests are ignored, including during bursts and waits of any length.
  - When i_x_wb_cyc = 0 (sampled in GNT_x): outputs are masked to 0 that cycle (cyc/stb forced 0), then go to IDLE.
  - Minimum one bus-idle cycle between transactions, which guarantees a CYC low gap for the slave.
- Ack gating:
  - Acks are never routed in IDLE; a stray i_wb_ack in IDLE is dropped.
  - An ack arriving in the same cycle the granted CYC falls is also dropped.
- Stall and hold: stb low inside a granted cycle is passed through; the grant is held.
- Simultaneous events: a new request by the same master in the release cycle is arbitrated normally in the next IDLE cycle; there is no back-to-back grant without IDLE.

Test Plan:
1. Reset: assert i_reset mid-GNT_D with a burst active -> same cycle o_wb_cyc = 0, o_grant = 00, both acks 0. After release, counter = 0.
2. Single code read: i_c_wb_cyc/stb = 1, adr = 0x0000_1000, cti = 000; slave acks 2 cycles later -> o_wb_adr = 0x1000 one cycle after request, o_c_wb_ack pulses once, o_d_wb_ack stays 0. The code cache drops cyc, then IDLE.
3. Contention: both request at the same cycle with STARVE_LIMIT = 4 -> data granted. Data requests continuously with code held; after 4 data grants the 5th contested arbitration grants code and the counter clears.
4. Burst integrity: data 4-beat burst (cti 010,010,010,111) at 0x2000. Code requests at beat 2 -> no output switch until data cyc falls; code granted 2 cycles after data cyc falls (mask cycle + IDLE).
5. Stray ack: i_wb_ack = 1 in IDLE -> o_c_wb_ack = o_d_wb_ack = 0.
6. STARVE_LIMIT = 0 build: both request -> code always granted first.

Source files
------------

// File: rtl/zap_wb_arbiter.sv
// ---------------------------------------------------------------------------
// zap_wb_arbiter
//
// Two-master Wishbone B3 arbiter that shares the external bus between the
// code cache port and the data cache port. Data normally wins a tie. A
// starvation counter forces a code grant once data has won STARVE_LIMIT
// contested arbitrations in a row. A grant is held for the whole CYC of the
// granted master, so incrementing bursts are never split. Each release costs
// one masked cycle plus one IDLE cycle, which gives the slave a CYC-low gap.
//
// Ports
//   i_clk, i_reset         clock, asynchronous active-high reset
//   i_c_wb_*               code master request (cyc/stb/wen/sel/dat/adr/cti)
//   o_c_wb_ack             ack routed to the code master
//   i_d_wb_*               data master request (same set as code)
//   o_d_wb_ack             ack routed to the data master
//   o_wb_*                 merged bus towards the bus-width adapter
//   i_wb_ack               slave ack (read data is broadcast elsewhere)
//   o_grant                01 = code, 10 = data, 00 = idle (registered)
// ---------------------------------------------------------------------------
module zap_wb_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned CNT_W        = 4
) (
   input  logic        i_clk,
   input  logic        i_reset,

   input  logic        i_c_wb_cyc,
   input  logic        i_c_wb_stb,
   input  logic        i_c_wb_wen,
   input  logic [3:0]  i_c_wb_sel,
   input  logic [31:0] i_c_wb_dat,
   input  logic [31:0] i_c_wb_adr,
   input  logic [2:0]  i_c_wb_cti,
   output logic        o_c_wb_ack,

   input  logic        i_d_wb_cyc,
   input  logic        i_d_wb_stb,
   input  logic        i_d_wb_wen,
   input  logic [3:0]  i_d_wb_sel,
   input  logic [31:0] i_d_wb_dat,
   input  logic [31:0] i_d_wb_adr,
   input  logic [2:0]  i_d_wb_cti,
   output logic        o_d_wb_ack,

   output logic        o_wb_cyc,
   output logic        o_wb_stb,
   output logic        o_wb_wen,
   output logic [3:0]  o_wb_sel,
   output logic [31:0] o_wb_dat,
   output logic [31:0] o_wb_adr,
   output logic [2:0]  o_wb_cti,
   input  logic        i_wb_ack,

   output logic [1:0]  o_grant
);

   // State encodings match the o_grant encoding on purpose.
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      GNT_C = 2'b01,
      GNT_D = 2'b10
   } state_t;

   localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg,   cnt_next;
   logic [1:0]       grant_reg, grant_next;

   // Per-master views, index 0 = code, 1 = data.
   logic        m_cyc [2];
   logic        m_stb [2];
   logic        m_wen [2];
   logic [3:0]  m_sel [2];
   logic [31:0] m_dat [2];
   logic [31:0] m_adr [2];
   logic [2:0]  m_cti [2];

   assign m_cyc[0] = i_c_wb_cyc;  assign m_cyc[1] = i_d_wb_cyc;
   assign m_stb[0] = i_c_wb_stb;  assign m_stb[1] = i_d_wb_stb;
   assign m_wen[0] = i_c_wb_wen;  assign m_wen[1] = i_d_wb_wen;
   assign m_sel[0] = i_c_wb_sel;  assign m_sel[1] = i_d_wb_sel;
   assign m_dat[0] = i_c_wb_dat;  assign m_dat[1] = i_d_wb_dat;
   assign m_adr[0] = i_c_wb_adr;  assign m_adr[1] = i_d_wb_adr;
   assign m_cti[0] = i_c_wb_cti;  assign m_cti[1] = i_d_wb_cti;

   // Selected master and whether its cycle is still live. When the granted
   // CYC has fallen the whole bus (and any ack) is masked for that cycle.
   logic sel_idx;
   logic pass;

   assign sel_idx = (state_reg == GNT_D);
   assign pass    = ((state_reg == GNT_C) && i_c_wb_cyc) ||
                    ((state_reg == GNT_D) && i_d_wb_cyc);

   always_comb begin
      o_wb_cyc = 1'b0;
      o_wb_stb = 1'b0;
      o_wb_wen = 1'b0;
      o_wb_sel = '0;
      o_wb_dat = '0;
      o_wb_adr = '0;
      o_wb_cti = '0;
      if (pass) begin
         o_wb_cyc = m_cyc[sel_idx];
         o_wb_stb = m_stb[sel_idx];
         o_wb_wen = m_wen[sel_idx];
         o_wb_sel = m_sel[sel_idx];
         o_wb_dat = m_dat[sel_idx];
         o_wb_adr = m_adr[sel_idx];
         o_wb_cti = m_cti[sel_idx];
      end
   end

   // Ack routing: only the granted, still-live master sees the slave ack.
   logic [1:0] ack_vec;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_ack
         assign ack_vec[gi] = pass && (sel_idx == 1'(gi)) && i_wb_ack;
      end
   endgenerate

   assign o_c_wb_ack = ack_vec[0];
   assign o_d_wb_ack = ack_vec[1];
   assign o_grant    = grant_reg;

   // Next-state, starvation counter and grant.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (i_c_wb_cyc && i_d_wb_cyc) begin
               if (cnt_reg >= LIMIT) begin
                  state_next = GNT_C;
                  cnt_next   = '0;
               end else begin
                  state_next = GNT_D;
                  if (cnt_reg != CNT_MAX) begin
                     cnt_next = cnt_reg + 1'b1;
                  end
               end
            end else if (i_c_wb_cyc) begin
               state_next = GNT_C;
               cnt_next   = '0;
            end else if (i_d_wb_cyc) begin
               // Uncontested data win leaves the counter untouched.
               state_next = GNT_D;
            end
         end
         GNT_C: begin
            if (!i_c_wb_cyc) begin
               state_next = IDLE;
            end
         end
         GNT_D: begin
            if (!i_d_wb_cyc) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      grant_next = state_next;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         grant_reg <= 2'b00;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         grant_reg <= grant_next;
      end
   end

endmodule

// File: tb/tb_zap_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_zap_wb_arbiter
//
// Directed bench for zap_wb_arbiter. One instance is built with
// STARVE_LIMIT = 4, a second with STARVE_LIMIT = 0; both share stimulus.
// Expected grants/addresses are pushed to a queue when a request is driven
// and popped when the slave ack is returned.
// ---------------------------------------------------------------------------
module tb_zap_wb_arbiter;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst;

   logic        c_cyc, c_stb, c_wen;
   logic [3:0]  c_sel;
   logic [31:0] c_dat, c_adr;
   logic [2:0]  c_cti;
   logic        d_cyc, d_stb, d_wen;
   logic [3:0]  d_sel;
   logic [31:0] d_dat, d_adr;
   logic [2:0]  d_cti;
   logic        wb_ack;

   logic        o_c_ack, o_d_ack;
   logic        o_cyc, o_stb, o_wen;
   logic [3:0]  o_sel;
   logic [31:0] o_dat, o_adr;
   logic [2:0]  o_cti;
   logic [1:0]  o_grant;

   logic        z_c_ack, z_d_ack;
   logic        z_cyc, z_stb, z_wen;
   logic [3:0]  z_sel;
   logic [31:0] z_dat, z_adr;
   logic [2:0]  z_cti;
   logic [1:0]  z_grant;

   always #5 clk = ~clk;

   zap_wb_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
      .i_clk(clk), .i_reset(rst),
      .i_c_wb_cyc(c_cyc), .i_c_wb_stb(c_stb), .i_c_wb_wen(c_wen),
      .i_c_wb_sel(c_sel), .i_c_wb_dat(c_dat), .i_c_wb_adr(c_adr),
      .i_c_wb_cti(c_cti), .o_c_wb_ack(o_c_ack),
      .i_d_wb_cyc(d_cyc), .i_d_wb_stb(d_stb), .i_d_wb_wen(d_wen),
      .i_d_wb_sel(d_sel), .i_d_wb_dat(d_dat), .i_d_wb_adr(d_adr),
      .i_d_wb_cti(d_cti), .o_d_wb_ack(o_d_ack),
      .o_wb_cyc(o_cyc), .o_wb_stb(o_stb), .o_wb_wen(o_wen),
      .o_wb_sel(o_sel), .o_wb_dat(o_dat), .o_wb_adr(o_adr),
      .o_wb_cti(o_cti), .i_wb_ack(wb_ack), .o_grant(o_grant)
   );

   zap_wb_arbiter #(.STARVE_LIMIT(0), .CNT_W(4)) dut_z (
      .i_clk(clk), .i_reset(rst),
      .i_c_wb_cyc(c_cyc), .i_c_wb_stb(c_stb), .i_c_wb_wen(c_wen),
      .i_c_wb_sel(c_sel), .i_c_wb_dat(c_dat), .i_c_wb_adr(c_adr),
      .i_c_wb_cti(c_cti), .o_c_wb_ack(z_c_ack),
      .i_d_wb_cyc(d_cyc), .i_d_wb_stb(d_stb), .i_d_wb_wen(d_wen),
      .i_d_wb_sel(d_sel), .i_d_wb_dat(d_dat), .i_d_wb_adr(d_adr),
      .i_d_wb_cti(d_cti), .o_d_wb_ack(z_d_ack),
      .o_wb_cyc(z_cyc), .o_wb_stb(z_stb), .o_wb_wen(z_wen),
      .o_wb_sel(z_sel), .o_wb_dat(z_dat), .o_wb_adr(z_adr),
      .o_wb_cti(z_cti), .i_wb_ack(wb_ack), .o_grant(z_grant)
   );

   typedef struct {
      logic [1:0]  grant;
      logic [31:0] adr;
      logic [2:0]  cti;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_err    = 0;
   int   model_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Compare one acked beat against the oldest expectation.
   task automatic pop_check();
      exp_t e;
      chk("sb_nonempty", 32'(sb.size() == 0), 32'd0);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk("beat_grant", 32'(o_grant), 32'(e.grant));
         chk("beat_adr", o_adr, e.adr);
         chk("beat_cti", 32'(o_cti), 32'(e.cti));
         chk("beat_c_ack", 32'(o_c_ack), 32'(e.grant == 2'b01));
         chk("beat_d_ack", 32'(o_d_ack), 32'(e.grant == 2'b10));
      end
   endtask

   // Arbitration decision of the STARVE_LIMIT = 4 instance, from IDLE.
   function automatic logic model_arb(input logic rc, input logic rd);
      logic win_c;
      if (rc && rd) win_c = (model_cnt >= LIMIT);
      else          win_c = rc;
      if (win_c)                     model_cnt = 0;
      else if (rc && model_cnt != 15) model_cnt++;
      return win_c;
   endfunction

   // One single-beat transaction starting in IDLE. The winner drops its CYC
   // after the ack (with a late ack in the release cycle); the loser keeps
   // requesting. Returns in IDLE.
   task automatic transact(input logic want_c, input logic want_d);
      exp_t e;
      logic win_c;
      if (want_c) begin c_cyc = 1'b1; c_stb = 1'b1; end
      if (want_d) begin d_cyc = 1'b1; d_stb = 1'b1; end
      c_cti = 3'b000;
      d_cti = 3'b000;
      win_c   = model_arb(c_cyc, d_cyc);
      e.grant = win_c ? 2'b01 : 2'b10;
      e.adr   = win_c ? c_adr : d_adr;
      e.cti   = 3'b000;
      sb.push_back(e);
      #2;
      chk("idle_cyc", 32'(o_cyc), 32'd0);
      chk("idle_grant", 32'(o_grant), 32'd0);
      tick();
      wb_ack = 1'b1;
      #2;
      chk("gnt_cyc", 32'(o_cyc), 32'd1);
      pop_check();
      tick();
      if (win_c) begin c_cyc = 1'b0; c_stb = 1'b0; end
      else       begin d_cyc = 1'b0; d_stb = 1'b0; end
      #2;
      chk("rel_cyc", 32'(o_cyc), 32'd0);
      chk("rel_acks", 32'({o_c_ack, o_d_ack}), 32'd0);
      chk("rel_grant", 32'(o_grant), 32'(e.grant));
      tick();
      wb_ack = 1'b0;
   endtask

   initial begin
      exp_t e;
      rst = 1'b1; wb_ack = 1'b0;
      c_cyc = 0; c_stb = 0; c_wen = 0; c_sel = 0; c_dat = 0; c_adr = 0; c_cti = 0;
      d_cyc = 0; d_stb = 0; d_wen = 0; d_sel = 0; d_dat = 0; d_adr = 0; d_cti = 0;
      tick();
      tick();
      chk("rst_outputs", 32'(|{o_cyc, o_stb, o_wen, o_sel, o_dat, o_adr, o_cti,
                               o_c_ack, o_d_ack, o_grant}), 32'd0);
      rst = 1'b0;
      tick();

      // Single code read with a stall cycle, ack two cycles after request.
      c_cyc = 1; c_stb = 1; c_adr = 32'h0000_1000; c_cti = 3'b000;
      c_sel = 4'hF; c_dat = 32'hCAFE_0001; c_wen = 1'b0;
      e.grant = 2'b01; e.adr = 32'h0000_1000; e.cti = 3'b000;
      sb.push_back(e);
      void'(model_arb(1'b1, 1'b0));
      #2;
      chk("code_latency_cyc", 32'(o_cyc), 32'd0);
      tick();
      chk("code_adr", o_adr, 32'h0000_1000);
      chk("code_grant", 32'(o_grant), 32'h1);
      chk("code_sel_dat", {o_sel, o_dat[27:0]}, {4'hF, 28'hAFE_0001});
      c_stb = 0;
      #2;
      chk("stall_stb", 32'(o_stb), 32'd0);
      chk("stall_grant", 32'(o_grant), 32'h1);
      tick();
      c_stb = 1; wb_ack = 1;
      #2;
      pop_check();
      tick();
      wb_ack = 0; c_cyc = 0; c_stb = 0;
      #2;
      chk("code_mask_cyc", 32'(o_cyc), 32'd0);
      chk("code_mask_ack", 32'(o_c_ack), 32'd0);
      tick();
      chk("code_idle_grant", 32'(o_grant), 32'd0);

      // Stray ack in IDLE.
      wb_ack = 1;
      #2;
      chk("stray_acks", 32'({o_c_ack, o_d_ack}), 32'd0);
      wb_ack = 0;
      tick();

      // Contention: LIMIT data wins, then code, then data again.
      c_adr = 32'h0000_1100; d_adr = 32'h0000_3000;
      for (int i = 0; i < LIMIT + 2; i++) transact(1'b1, 1'b1);

      // Reset mid-burst of a contested data grant.
      transact(1'b1, 1'b1);
      c_cyc = 1; c_stb = 1; d_cyc = 1; d_stb = 1; d_cti = 3'b010;
      void'(model_arb(1'b1, 1'b1));
      tick();
      chk("pre_rst_grant", 32'(o_grant), 32'h2);
      wb_ack = 1;
      #2;
      chk("pre_rst_dack", 32'(o_d_ack), 32'd1);
      rst = 1;
      #1;
      chk("rst_mid_outputs", 32'(|{o_cyc, o_stb, o_wen, o_sel, o_dat, o_adr, o_cti,
                                   o_c_ack, o_d_ack, o_grant}), 32'd0);
      model_cnt = 0;
      tick();
      rst = 0; wb_ack = 0;
      c_cyc = 0; c_stb = 0; d_cyc = 0; d_stb = 0; d_cti = 0;
      tick();
      for (int i = 0; i < LIMIT + 1; i++) transact(1'b1, 1'b1);

      // Four-beat data burst; code requests at beat 2.
      d_cyc = 1; d_stb = 1; d_adr = 32'h0000_2000; d_cti = 3'b010;
      void'(model_arb(c_cyc, 1'b1));
      for (int b = 0; b < 4; b++) begin
         e.grant = 2'b10;
         e.adr   = 32'h0000_2000 + 32'(4 * b);
         e.cti   = (b == 3) ? 3'b111 : 3'b010;
         sb.push_back(e);
      end
      tick();
      for (int b = 0; b < 4; b++) begin
         d_adr = 32'h0000_2000 + 32'(4 * b);
         d_cti = (b == 3) ? 3'b111 : 3'b010;
         if (b == 1) begin c_cyc = 1; c_stb = 1; end
         wb_ack = 1;
         #2;
         pop_check();
         tick();
      end
      wb_ack = 0; d_cyc = 0; d_stb = 0; d_cti = 0;
      #2;
      chk("burst_mask_cyc", 32'(o_cyc), 32'd0);
      chk("burst_mask_grant", 32'(o_grant), 32'h2);
      tick();
      chk("burst_idle_cyc", 32'(o_cyc), 32'd0);
      chk("burst_idle_grant", 32'(o_grant), 32'd0);
      void'(model_arb(1'b1, 1'b0));
      e.grant = 2'b01; e.adr = c_adr; e.cti = 3'b000;
      sb.push_back(e);
      tick();
      wb_ack = 1;
      #2;
      pop_check();
      tick();
      wb_ack = 0; c_cyc = 0; c_stb = 0;
      tick();

      // STARVE_LIMIT = 0 instance: code wins every tie.
      rst = 1;
      tick();
      rst = 0;
      c_cyc = 1; c_stb = 1; d_cyc = 1; d_stb = 1;
      c_adr = 32'h0000_4000; d_adr = 32'h0000_5000;
      tick();
      chk("z_first_grant", 32'(z_grant), 32'h1);
      chk("z_first_adr", z_adr, 32'h0000_4000);
      chk("main_first_grant", 32'(o_grant), 32'h2);
      c_cyc = 0; c_stb = 0;
      #2;
      chk("z_mask_outputs", 32'(|{z_cyc, z_stb, z_wen, z_sel, z_dat, z_cti, z_adr,
                                  z_c_ack, z_d_ack}), 32'd0);
      tick();
      chk("z_idle_grant", 32'(z_grant), 32'd0);
      c_cyc = 1; c_stb = 1;
      tick();
      chk("z_second_grant", 32'(z_grant), 32'h1);
      c_cyc = 0; c_stb = 0; d_cyc = 0; d_stb = 0;
      tick();

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
